// File: rtl/fpu_share_sched.sv
// Round-robin scheduler sharing one fixed-latency FPU among NUM_REQ requesters,
// routing results back by tag and keeping per-requester sticky IEEE flags.
module fpu_share_sched #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 2,
    parameter int C_OP    = 32,
    parameter int C_CMD   = 4
) (
    input  logic                       Clk_CI,
    input  logic                       Rst_RBI,
    input  logic [NUM_REQ-1:0]         Req_SI,
    input  logic [NUM_REQ*C_OP-1:0]    Operand_a_DI,
    input  logic [NUM_REQ*C_OP-1:0]    Operand_b_DI,
    input  logic [NUM_REQ*C_CMD-1:0]   Op_DI,
    output logic [NUM_REQ-1:0]         Gnt_SO,
    output logic [NUM_REQ-1:0]         Valid_SO,
    output logic [C_OP-1:0]            Result_DO,
    output logic [4:0]                 Flags_DO,
    input  logic [NUM_REQ-1:0]         StickyClr_SI,
    output logic [NUM_REQ*4-1:0]       Sticky_DO,
    output logic                       FpuEn_SO,
    output logic [C_OP-1:0]            FpuOp_a_DO,
    output logic [C_OP-1:0]            FpuOp_b_DO,
    output logic [C_CMD-1:0]           FpuOp_SO,
    input  logic [C_OP-1:0]            FpuRes_DI,
    input  logic                       FpuIV_SI,
    input  logic                       FpuOF_SI,
    input  logic                       FpuUF_SI,
    input  logic                       FpuZero_SI,
    input  logic                       FpuIX_SI
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_any;
    logic [IDX_W-1:0] cand_idx;
    int               cand;

    logic [LATENCY-1:0] pipe_vld;
    logic [IDX_W-1:0]   pipe_tag [LATENCY];
    logic               ret_vld;
    logic [IDX_W-1:0]   ret_tag;

    logic [3:0] sticky_q [NUM_REQ];

    // Scan from the pointer upward with wrap; grants are suppressed while in reset.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        Gnt_SO   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!gnt_any && Rst_RBI && Req_SI[cand_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = cand_idx;
            end
        end
        if (gnt_any) begin
            Gnt_SO[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            ptr_q <= '0;
        end else if (gnt_any) begin
            ptr_q <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    always_comb begin
        FpuEn_SO   = gnt_any;
        FpuOp_a_DO = '0;
        FpuOp_b_DO = '0;
        FpuOp_SO   = '0;
        if (gnt_any) begin
            FpuOp_a_DO = Operand_a_DI[int'(gnt_idx)*C_OP +: C_OP];
            FpuOp_b_DO = Operand_b_DI[int'(gnt_idx)*C_OP +: C_OP];
            FpuOp_SO   = Op_DI[int'(gnt_idx)*C_CMD +: C_CMD];
        end
    end

    // Only valid bits are reset; tags are qualified by them and need no reset.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= gnt_any;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge Clk_CI) begin
        pipe_tag[0] <= gnt_idx;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_tag[i] <= pipe_tag[i-1];
        end
    end

    assign ret_vld = pipe_vld[LATENCY-1];
    assign ret_tag = pipe_tag[LATENCY-1];

    always_comb begin
        Valid_SO  = '0;
        Result_DO = '0;
        Flags_DO  = '0;
        if (ret_vld) begin
            Valid_SO[ret_tag] = 1'b1;
            Result_DO         = FpuRes_DI;
            Flags_DO          = {FpuIV_SI, FpuOF_SI, FpuUF_SI, FpuZero_SI, FpuIX_SI};
        end
    end

    // A clear drops old bits but never masks flags returning in the same cycle.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                sticky_q[j] <= 4'b0;
            end
        end else begin
            for (int j = 0; j < NUM_REQ; j++) begin
                sticky_q[j] <= (StickyClr_SI[j] ? 4'b0 : sticky_q[j])
                             | ((ret_vld && ret_tag == IDX_W'(j))
                                ? {FpuIV_SI, FpuOF_SI, FpuUF_SI, FpuIX_SI} : 4'b0);
            end
        end
    end

    always_comb begin
        Sticky_DO = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            Sticky_DO[j*4 +: 4] = sticky_q[j];
        end
    end

endmodule

// File: tb/tb_fpu_share_sched.sv
// Directed scoreboard bench for fpu_share_sched with a two-stage FPU stub
// whose result is a+b and whose flags are operand b[4:0].
module tb_fpu_share_sched;

    localparam int NUM_REQ = 4;
    localparam int LATENCY = 2;
    localparam int C_OP    = 32;
    localparam int C_CMD   = 4;

    logic                     Clk_CI;
    logic                     Rst_RBI;
    logic [NUM_REQ-1:0]       Req_SI;
    logic [NUM_REQ*C_OP-1:0]  Operand_a_DI;
    logic [NUM_REQ*C_OP-1:0]  Operand_b_DI;
    logic [NUM_REQ*C_CMD-1:0] Op_DI;
    logic [NUM_REQ-1:0]       Gnt_SO;
    logic [NUM_REQ-1:0]       Valid_SO;
    logic [C_OP-1:0]          Result_DO;
    logic [4:0]               Flags_DO;
    logic [NUM_REQ-1:0]       StickyClr_SI;
    logic [NUM_REQ*4-1:0]     Sticky_DO;
    logic                     FpuEn_SO;
    logic [C_OP-1:0]          FpuOp_a_DO;
    logic [C_OP-1:0]          FpuOp_b_DO;
    logic [C_CMD-1:0]         FpuOp_SO;
    logic [C_OP-1:0]          FpuRes_DI;
    logic                     FpuIV_SI, FpuOF_SI, FpuUF_SI, FpuZero_SI, FpuIX_SI;

    fpu_share_sched #(
        .NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .C_OP(C_OP), .C_CMD(C_CMD)
    ) dut (
        .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI), .Req_SI(Req_SI),
        .Operand_a_DI(Operand_a_DI), .Operand_b_DI(Operand_b_DI), .Op_DI(Op_DI),
        .Gnt_SO(Gnt_SO), .Valid_SO(Valid_SO), .Result_DO(Result_DO), .Flags_DO(Flags_DO),
        .StickyClr_SI(StickyClr_SI), .Sticky_DO(Sticky_DO), .FpuEn_SO(FpuEn_SO),
        .FpuOp_a_DO(FpuOp_a_DO), .FpuOp_b_DO(FpuOp_b_DO), .FpuOp_SO(FpuOp_SO),
        .FpuRes_DI(FpuRes_DI), .FpuIV_SI(FpuIV_SI), .FpuOF_SI(FpuOF_SI),
        .FpuUF_SI(FpuUF_SI), .FpuZero_SI(FpuZero_SI), .FpuIX_SI(FpuIX_SI)
    );

    initial Clk_CI = 1'b0;
    always #5 Clk_CI = ~Clk_CI;

    int cyc = 0;
    always @(posedge Clk_CI) cyc <= cyc + 1;

    // FPU stub: garbage on its outputs when idle so the DUT's gating is visible.
    logic        s0_v, s1_v;
    logic [31:0] s0_res, s1_res;
    logic [4:0]  s0_f, s1_f;
    initial begin
        s0_v = 1'b0;
        s1_v = 1'b0;
    end
    always @(posedge Clk_CI) begin
        s1_v   <= s0_v;
        s1_res <= s0_res;
        s1_f   <= s0_f;
        s0_v   <= FpuEn_SO;
        s0_res <= FpuOp_a_DO + FpuOp_b_DO;
        s0_f   <= FpuOp_b_DO[4:0];
    end
    assign FpuRes_DI = s1_v ? s1_res : 32'hDEAD_BEEF;
    assign {FpuIV_SI, FpuOF_SI, FpuUF_SI, FpuZero_SI, FpuIX_SI} = s1_v ? s1_f : 5'b11111;

    typedef struct {
        int          tag;
        logic [31:0] res;
        logic [4:0]  flg;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   seq = 0;
    bit   sb_en = 1'b1;
    logic [4:0] flag_cfg [NUM_REQ];

    function automatic logic [31:0] a_val(input int i);
        return 32'h0100_0000 * (i + 1) + 32'(seq);
    endfunction

    function automatic logic [31:0] b_val(input int i);
        return (32'(i) << 8) | {27'b0, flag_cfg[i]};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] req, input logic [3:0] exp_gnt, input logic [3:0] clr);
        int   g;
        exp_t e;
        @(posedge Clk_CI);
        #1;
        seq++;
        Rst_RBI      = 1'b1;
        Req_SI       = req;
        StickyClr_SI = clr;
        for (int i = 0; i < NUM_REQ; i++) begin
            Operand_a_DI[i*C_OP +: C_OP]   = a_val(i);
            Operand_b_DI[i*C_OP +: C_OP]   = b_val(i);
            Op_DI[i*C_CMD +: C_CMD]        = C_CMD'(i + 5);
        end
        @(negedge Clk_CI);
        check_output("gnt", 32'(Gnt_SO), 32'(exp_gnt));
        if (exp_gnt != 4'b0) begin
            g = 0;
            for (int i = 0; i < NUM_REQ; i++) if (exp_gnt[i]) g = i;
            check_output("fpu_en", 32'(FpuEn_SO), 32'd1);
            check_output("fpu_op_a", FpuOp_a_DO, a_val(g));
            check_output("fpu_op", 32'(FpuOp_SO), 32'(g + 5));
            if (sb_en) begin
                e.tag = g;
                e.res = a_val(g) + b_val(g);
                e.flg = flag_cfg[g];
                e.cyc = cyc + LATENCY;
                sb.push_back(e);
            end
        end else begin
            check_output("fpu_idle", {FpuEn_SO, FpuOp_a_DO[30:0]}, 32'd0);
        end
    endtask

    task automatic reset_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk_CI);
            #1;
            Rst_RBI      = 1'b0;
            Req_SI       = 4'b1111;
            StickyClr_SI = 4'b0;
            @(negedge Clk_CI);
            check_output("rst_gnt", 32'(Gnt_SO), 32'd0);
            check_output("rst_fpu_en", 32'(FpuEn_SO), 32'd0);
            check_output("rst_sticky", 32'(Sticky_DO), 32'd0);
        end
    endtask

    // Monitor: every presented result is matched against the oldest expectation.
    always @(negedge Clk_CI) begin
        exp_t e;
        if (Valid_SO != 4'b0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_valid at cycle %0d: got %b, expected none", cyc, Valid_SO);
            end else begin
                e = sb.pop_front();
                check_output("ret_valid", 32'(Valid_SO), 32'(1) << e.tag);
                check_output("ret_result", Result_DO, e.res);
                check_output("ret_flags", 32'(Flags_DO), 32'(e.flg));
                check_output("ret_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else begin
            check_output("idle_out", {Flags_DO, Result_DO[26:0]}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < NUM_REQ; i++) flag_cfg[i] = 5'b0;
        Rst_RBI      = 1'b0;
        Req_SI       = 4'b1111;
        StickyClr_SI = 4'b0;
        Operand_a_DI = '0;
        Operand_b_DI = '0;
        Op_DI        = '0;

        reset_cycles(2);
        apply_stimulus(4'b1111, 4'b0001, 4'b0);
        apply_stimulus(4'b1111, 4'b0010, 4'b0);
        apply_stimulus(4'b1111, 4'b0100, 4'b0);
        apply_stimulus(4'b1111, 4'b1000, 4'b0);
        apply_stimulus(4'b1111, 4'b0001, 4'b0);

        apply_stimulus(4'b0100, 4'b0100, 4'b0);
        apply_stimulus(4'b0000, 4'b0000, 4'b0);
        apply_stimulus(4'b0000, 4'b0000, 4'b0);

        apply_stimulus(4'b1010, 4'b1000, 4'b0);
        apply_stimulus(4'b1010, 4'b0010, 4'b0);
        apply_stimulus(4'b1010, 4'b1000, 4'b0);
        apply_stimulus(4'b1010, 4'b0010, 4'b0);
        apply_stimulus(4'b0000, 4'b0000, 4'b0);
        apply_stimulus(4'b0000, 4'b0000, 4'b0);

        flag_cfg[1] = 5'b01001;
        apply_stimulus(4'b0010, 4'b0010, 4'b0);
        repeat (3) apply_stimulus(4'b0000, 4'b0000, 4'b0);
        check_output("sticky_of_ix", 32'(Sticky_DO), 32'h0050);

        flag_cfg[1] = 5'b00100;
        apply_stimulus(4'b0010, 4'b0010, 4'b0);
        repeat (3) apply_stimulus(4'b0000, 4'b0000, 4'b0);
        check_output("sticky_accum", 32'(Sticky_DO), 32'h0070);

        flag_cfg[1] = 5'b10000;
        apply_stimulus(4'b0010, 4'b0010, 4'b0);
        apply_stimulus(4'b0000, 4'b0000, 4'b0);
        apply_stimulus(4'b0000, 4'b0000, 4'b0010);
        apply_stimulus(4'b0000, 4'b0000, 4'b0);
        check_output("sticky_clr_ret", 32'(Sticky_DO), 32'h0080);

        apply_stimulus(4'b1001, 4'b1000, 4'b0);
        apply_stimulus(4'b1001, 4'b0001, 4'b0);
        apply_stimulus(4'b0000, 4'b0000, 4'b0);
        apply_stimulus(4'b0000, 4'b0000, 4'b0);

        sb_en = 1'b0;
        apply_stimulus(4'b1111, 4'b0010, 4'b0);
        apply_stimulus(4'b1111, 4'b0100, 4'b0);
        sb_en = 1'b1;
        reset_cycles(2);
        apply_stimulus(4'b1100, 4'b0100, 4'b0);
        repeat (4) apply_stimulus(4'b0000, 4'b0000, 4'b0);
        check_output("sticky_after_rst", 32'(Sticky_DO), 32'h0000);

        check_output("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
